// File: rtl/dac_word_sequencer.sv
// dac_word_sequencer: buffers channel/code writes and issues 16-bit DAC words
// to the SPI master with done/timeout handling. Option: DAC_SEQ_LDAC_EN (LDAC_n strobe).
module dac_word_sequencer #(
  parameter int FIFO_AW        = 2,
  parameter int GAP_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic        WordValid,
  output logic        WordReady,
  input  logic [1:0]  Channel,
  input  logic [11:0] Code,
  output logic [15:0] SerialData,
  output logic        DataoutStart,
  input  logic        DataoutDone,
  output logic        Busy,
  output logic        TimeoutErr,
  input  logic        ErrClear,
  output logic [7:0]  WordCount
`ifdef DAC_SEQ_LDAC_EN
  ,
  output logic        LDAC_n
`endif
);

  localparam int         DEPTH    = 1 << FIFO_AW;
  localparam logic [9:0] TO_LAST  = 10'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_GAP
`ifdef DAC_SEQ_LDAC_EN
    ,
    S_LDAC
`endif
  } state_t;

  logic [15:0]      mem_q [DEPTH];
  logic [FIFO_AW:0] wr_ptr_q;
  logic [FIFO_AW:0] rd_ptr_q;
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;

  state_t           state_q;
  logic [9:0]       timer_q;
  logic [7:0]       gap_q;
  logic [15:0]      data_q;
  logic             start_q;
  logic             err_q;
  logic [7:0]       cnt_q;
`ifdef DAC_SEQ_LDAC_EN
  logic             ldac_n_q;
  logic             ldac_cnt_q;
`endif

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                 (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
  assign push  = WordValid && !full;
  assign pop   = (state_q == S_IDLE) && !empty;

  assign WordReady    = !full;
  assign Busy         = (state_q != S_IDLE) || !empty;
  assign SerialData   = data_q;
  assign DataoutStart = start_q;
  assign TimeoutErr   = err_q;
  assign WordCount    = cnt_q;
`ifdef DAC_SEQ_LDAC_EN
  assign LDAC_n       = ldac_n_q;
`endif

  // Word storage: formatted at push so the issue path is a plain read.
  always_ff @(posedge Clk) begin
    if (push) begin
      mem_q[wr_ptr_q[FIFO_AW-1:0]] <= {Channel, 2'b01, Code};
    end
  end

  // FIFO pointers with an extra wrap bit to tell full from empty.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // Issue FSM: start, wait for done or timeout, then hold CS-high gap.
  always_ff @(posedge Clk) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      timer_q    <= '0;
      gap_q      <= '0;
      data_q     <= '0;
      start_q    <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
`ifdef DAC_SEQ_LDAC_EN
      ldac_n_q   <= 1'b1;
      ldac_cnt_q <= 1'b0;
`endif
    end else begin
      start_q <= 1'b0;
      if (ErrClear) err_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (pop) begin
            data_q  <= mem_q[rd_ptr_q[FIFO_AW-1:0]];
            start_q <= 1'b1;
            timer_q <= '0;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (DataoutDone) begin
            cnt_q   <= cnt_q + 8'd1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else if (timer_q == TO_LAST) begin
            if (!ErrClear) err_q <= 1'b1;
            gap_q   <= '0;
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q + 10'd1;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
`ifdef DAC_SEQ_LDAC_EN
            if (empty) begin
              ldac_n_q   <= 1'b0;
              ldac_cnt_q <= 1'b0;
              state_q    <= S_LDAC;
            end else begin
              state_q    <= S_IDLE;
            end
`else
            state_q <= S_IDLE;
`endif
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
`ifdef DAC_SEQ_LDAC_EN
        S_LDAC: begin
          if (ldac_cnt_q) begin
            ldac_n_q <= 1'b1;
            state_q  <= S_IDLE;
          end else begin
            ldac_cnt_q <= 1'b1;
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dac_word_sequencer.sv
// tb_dac_word_sequencer: directed checks of issue timing, backpressure,
// timeout, stray done, mid-transfer reset and WordCount wrap.
module tb_dac_word_sequencer;

  localparam int GAP = 4;
  localparam int TMO = 64;

  logic        clk;
  logic        reset_n;
  logic        WordValid;
  logic        WordReady;
  logic [1:0]  Channel;
  logic [11:0] Code;
  logic [15:0] SerialData;
  logic        DataoutStart;
  logic        DataoutDone;
  logic        manual_done;
  logic        auto_done;
  logic        Busy;
  logic        TimeoutErr;
  logic        ErrClear;
  logic [7:0]  WordCount;
`ifdef DAC_SEQ_LDAC_EN
  logic        LDAC_n;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic        auto_en    = 1'b0;
  int          auto_delay = 1;

  int          st_log [$];
  int          dn_log [$];
  logic [15:0] sd_log [$];

  assign DataoutDone = manual_done | auto_done;

  dac_word_sequencer #(
    .FIFO_AW(2),
    .GAP_CYCLES(GAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .Clk(clk),
    .reset_n(reset_n),
    .WordValid(WordValid),
    .WordReady(WordReady),
    .Channel(Channel),
    .Code(Code),
    .SerialData(SerialData),
    .DataoutStart(DataoutStart),
    .DataoutDone(DataoutDone),
    .Busy(Busy),
    .TimeoutErr(TimeoutErr),
    .ErrClear(ErrClear),
    .WordCount(WordCount)
`ifdef DAC_SEQ_LDAC_EN
    ,
    .LDAC_n(LDAC_n)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log start/done edges (cyc = index of the edge concerned).
  always begin
    @(posedge clk);
    #2;
    if (DataoutStart) begin
      st_log.push_back(cyc);
      sd_log.push_back(SerialData);
    end
    if (DataoutDone) dn_log.push_back(cyc);
  end

  // SPI master stand-in: done pulse auto_delay cycles after each start.
  initial auto_done = 1'b0;
  always begin
    @(negedge clk);
    if (auto_en && DataoutStart) begin
      repeat (auto_delay) @(negedge clk);
      auto_done = 1'b1;
      @(negedge clk);
      auto_done = 1'b0;
    end
  end

  task automatic push_word(input logic [1:0] ch, input logic [11:0] cd,
                           output int waited);
    WordValid = 1'b1;
    Channel   = ch;
    Code      = cd;
    waited    = 0;
    while (!WordReady && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    WordValid = 1'b0;
  endtask

  task automatic test_reset();
    reset_n     = 1'b0;
    WordValid   = 1'b0;
    Channel     = '0;
    Code        = '0;
    manual_done = 1'b0;
    ErrClear    = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (SerialData !== 16'h0000) begin
      n_fail++;
      $display("FAIL rst_sd: got %h want 0000", SerialData);
    end
    n_checks++;
    if (DataoutStart !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_start: got %b want 0", DataoutStart);
    end
    n_checks++;
    if (TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_err: got %b want 0", TimeoutErr);
    end
    n_checks++;
    if (WordCount !== 8'd0) begin
      n_fail++;
      $display("FAIL rst_cnt: got %0d want 0", WordCount);
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy: got %b want 0", Busy);
    end
    n_checks++;
    if (WordReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ready: got %b want 1", WordReady);
    end
`ifdef DAC_SEQ_LDAC_EN
    n_checks++;
    if (LDAC_n !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_ldac: got %b want 1", LDAC_n);
    end
`endif
  endtask

  task automatic test_single_word();
    logic [7:0] wc0;
    wc0       = WordCount;
    WordValid = 1'b1;
    Channel   = 2'd2;
    Code      = 12'hABC;
    @(negedge clk);
    WordValid = 1'b0;
    n_checks++;
    if (DataoutStart !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_n: start=%b busy=%b want 0/1", DataoutStart, Busy);
    end
    @(negedge clk);
    n_checks++;
    if (DataoutStart !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_start: got %b want 1", DataoutStart);
    end
    n_checks++;
    if (SerialData !== 16'h9ABC) begin
      n_fail++;
      $display("FAIL sw_data: got %h want 9abc", SerialData);
    end
    @(negedge clk);
    n_checks++;
    if (DataoutStart !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_pulse: got %b want 0", DataoutStart);
    end
    repeat (38) @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    n_checks++;
    if (WordCount !== wc0 + 8'd1) begin
      n_fail++;
      $display("FAIL sw_cnt: got %0d want %0d", WordCount, wc0 + 8'd1);
    end
    n_checks++;
    if (SerialData !== 16'h9ABC || TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_hold: sd=%h err=%b want 9abc/0", SerialData, TimeoutErr);
    end
    repeat (3) @(negedge clk);
    n_checks++;
    if (Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_gapbusy: got %b want 1", Busy);
    end
    @(negedge clk);
`ifdef DAC_SEQ_LDAC_EN
    n_checks++;
    if (LDAC_n !== 1'b0 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_ldac0: ldac=%b busy=%b want 0/1", LDAC_n, Busy);
    end
    @(negedge clk);
    n_checks++;
    if (LDAC_n !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_ldac1: got %b want 0", LDAC_n);
    end
    @(negedge clk);
    n_checks++;
    if (LDAC_n !== 1'b1) begin
      n_fail++;
      $display("FAIL sw_ldac2: got %b want 1", LDAC_n);
    end
`endif
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sw_idle: busy got %b want 0", Busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  ch  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    logic [11:0] cd  [6] = '{12'h001, 12'h234, 12'h567,
                             12'h89A, 12'hBCD, 12'hEF0};
    logic [15:0] exp [6] = '{16'h1001, 16'h5234, 16'h9567,
                             16'hD89A, 16'h1BCD, 16'h5EF0};
    int          w   [6];
    int          n;
    logic [7:0]  wc0;
    wc0 = WordCount;
    st_log.delete();
    dn_log.delete();
    sd_log.delete();
    auto_delay = 3;
    auto_en    = 1'b1;
    for (int i = 0; i < 6; i++) push_word(ch[i], cd[i], w[i]);
    n_checks++;
    if (w[0] + w[1] + w[2] + w[3] + w[4] != 0) begin
      n_fail++;
      $display("FAIL bp_first4: stalls %0d want 0",
               w[0] + w[1] + w[2] + w[3] + w[4]);
    end
    n_checks++;
    if (w[5] == 0 || w[5] >= 1000) begin
      n_fail++;
      $display("FAIL bp_stall: stall cycles %0d want 1..999", w[5]);
    end
    n = 0;
    while ((dn_log.size() < 6 || Busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    auto_en = 1'b0;
    n_checks++;
    if (n >= 2000 || sd_log.size() != 6) begin
      n_fail++;
      $display("FAIL bp_drain: starts %0d want 6", sd_log.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (sd_log[i] !== exp[i]) begin
          n_fail++;
          $display("FAIL bp_order%0d: got %h want %h", i, sd_log[i], exp[i]);
        end
      end
      for (int i = 1; i < 6; i++) begin
        n_checks++;
        if (st_log[i] - dn_log[i-1] != GAP + 1) begin
          n_fail++;
          $display("FAIL bp_gap%0d: got %0d want %0d",
                   i, st_log[i] - dn_log[i-1], GAP + 1);
        end
      end
    end
    n_checks++;
    if (WordCount !== wc0 + 8'd6) begin
      n_fail++;
      $display("FAIL bp_cnt: got %0d want %0d", WordCount, wc0 + 8'd6);
    end
  endtask

  task automatic test_timeout();
    int         w;
    int         n;
    int         sa;
    int         sb;
    logic [7:0] wc0;
    wc0 = WordCount;
    push_word(2'd1, 12'h123, w);
    push_word(2'd3, 12'hFFF, w);
    n = 0;
    while (!DataoutStart && n < 10) begin
      @(negedge clk);
      n++;
    end
    sa = cyc;
    n_checks++;
    if (n >= 10 || SerialData !== 16'h5123) begin
      n_fail++;
      $display("FAIL to_startA: sd=%h want 5123", SerialData);
    end
    while (cyc < sa + TMO - 1) @(negedge clk);
    n_checks++;
    if (TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_early: got %b want 0", TimeoutErr);
    end
    @(negedge clk);
    n_checks++;
    if (TimeoutErr !== 1'b1) begin
      n_fail++;
      $display("FAIL to_rise: got %b want 1", TimeoutErr);
    end
    n_checks++;
    if (WordCount !== wc0) begin
      n_fail++;
      $display("FAIL to_cnt: got %0d want %0d", WordCount, wc0);
    end
    ErrClear = 1'b1;
    @(negedge clk);
    ErrClear = 1'b0;
    n_checks++;
    if (TimeoutErr !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: got %b want 0", TimeoutErr);
    end
    n = 0;
    while (!DataoutStart && n < 20) begin
      @(negedge clk);
      n++;
    end
    sb = cyc;
    n_checks++;
    if (n >= 20 || SerialData !== 16'hDFFF) begin
      n_fail++;
      $display("FAIL to_startB: sd=%h want dfff", SerialData);
    end
    n_checks++;
    if (sb != sa + TMO + GAP + 1) begin
      n_fail++;
      $display("FAIL to_nextB: edge %0d want %0d", sb, sa + TMO + GAP + 1);
    end
    while (cyc < sb + TMO - 1) @(negedge clk);
    ErrClear = 1'b1;
    @(negedge clk);
    ErrClear = 1'b0;
    n_checks++;
    if (TimeoutErr !== 1'b0 || WordCount !== wc0) begin
      n_fail++;
      $display("FAIL to_prio: err=%b cnt=%0d want 0/%0d",
               TimeoutErr, WordCount, wc0);
    end
    n = 0;
    while (Busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL to_idle: busy got %b want 0", Busy);
    end
  endtask

  task automatic test_stray_done();
    int         w;
    int         n;
    logic [7:0] wc0;
    wc0         = WordCount;
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    n_checks++;
    if (WordCount !== wc0 || Busy !== 1'b0 || DataoutStart !== 1'b0) begin
      n_fail++;
      $display("FAIL sd_idle: cnt=%0d busy=%b start=%b want %0d/0/0",
               WordCount, Busy, DataoutStart, wc0);
    end
    push_word(2'd0, 12'h055, w);
    n = 0;
    while (!DataoutStart && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= 10 || SerialData !== 16'h1055) begin
      n_fail++;
      $display("FAIL sd_start: sd=%h want 1055", SerialData);
    end
    @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    n_checks++;
    if (WordCount !== wc0 + 8'd1) begin
      n_fail++;
      $display("FAIL sd_done: got %0d want %0d", WordCount, wc0 + 8'd1);
    end
    @(negedge clk);
    manual_done = 1'b1;
    @(negedge clk);
    manual_done = 1'b0;
    @(negedge clk);
    n_checks++;
    if (WordCount !== wc0 + 8'd1 || Busy !== 1'b1) begin
      n_fail++;
      $display("FAIL sd_gap: cnt=%0d busy=%b want %0d/1",
               WordCount, Busy, wc0 + 8'd1);
    end
    @(negedge clk);
`ifdef DAC_SEQ_LDAC_EN
    n_checks++;
    if (LDAC_n !== 1'b0) begin
      n_fail++;
      $display("FAIL sd_ldac: got %b want 0", LDAC_n);
    end
`else
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL sd_gapend: busy got %b want 0", Busy);
    end
`endif
    n = 0;
    while (Busy && n < 10) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (Busy !== 1'b0 || WordCount !== wc0 + 8'd1) begin
      n_fail++;
      $display("FAIL sd_end: busy=%b cnt=%0d want 0/%0d",
               Busy, WordCount, wc0 + 8'd1);
    end
  endtask

  task automatic test_reset_mid();
    int w;
    push_word(2'd1, 12'h111, w);
    push_word(2'd2, 12'h222, w);
    push_word(2'd3, 12'h333, w);
    push_word(2'd0, 12'h444, w);
    repeat (5) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (SerialData !== 16'h0000 || DataoutStart !== 1'b0 ||
        TimeoutErr !== 1'b0 || WordCount !== 8'd0) begin
      n_fail++;
      $display("FAIL rm_out: sd=%h start=%b err=%b cnt=%0d want 0000/0/0/0",
               SerialData, DataoutStart, TimeoutErr, WordCount);
    end
    n_checks++;
    if (Busy !== 1'b0 || WordReady !== 1'b1) begin
      n_fail++;
      $display("FAIL rm_fifo: busy=%b ready=%b want 0/1", Busy, WordReady);
    end
    reset_n = 1'b1;
    st_log.delete();
    repeat (20) @(negedge clk);
    n_checks++;
    if (st_log.size() != 0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rm_quiet: starts=%0d busy=%b want 0/0",
               st_log.size(), Busy);
    end
  endtask

  task automatic test_count_wrap();
    int w;
    int stalls_bad;
    int n;
    stalls_bad = 0;
    dn_log.delete();
    auto_delay = 1;
    auto_en    = 1'b1;
    for (int i = 0; i < 256; i++) begin
      push_word(2'(i), 12'(i * 7), w);
      if (w >= 1000) stalls_bad++;
    end
    n = 0;
    while ((dn_log.size() < 256 || Busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    auto_en = 1'b0;
    n_checks++;
    if (stalls_bad != 0 || n >= 5000) begin
      n_fail++;
      $display("FAIL wr_flow: stuck pushes %0d drain %0d", stalls_bad, n);
    end
    n_checks++;
    if (dn_log.size() != 256) begin
      n_fail++;
      $display("FAIL wr_dones: got %0d want 256", dn_log.size());
    end
    n_checks++;
    if (WordCount !== 8'd0) begin
      n_fail++;
      $display("FAIL wr_cnt: got %0d want 0", WordCount);
    end
  endtask

  initial begin
    test_reset();
    test_single_word();
    test_back_to_back();
    test_timeout();
    test_stray_done();
    test_reset_mid();
    test_count_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
